// File: rtl/periph_input_decoder_if.sv
// periph_input_decoder_if: sample strobe/data in, debounced button events out
interface periph_input_decoder_if #(
    parameter int ADC_WIDTH = 12,
    parameter int NUM_CH = 5
);
    logic sample_valid;
    logic [NUM_CH*ADC_WIDTH-1:0] ch_data;
    logic [2*NUM_CH-1:0] btn_level;
    logic [2*NUM_CH-1:0] btn_press;
    logic [2*NUM_CH-1:0] btn_release;
    logic [2*NUM_CH-1:0] btn_repeat;
    modport master (
        output sample_valid, ch_data,
        input btn_level, btn_press, btn_release, btn_repeat
    );
    modport slave (
        input sample_valid, ch_data,
        output btn_level, btn_press, btn_release, btn_repeat
    );
endinterface

// File: rtl/periph_input_decoder.sv
// periph_input_decoder: ADC band decode into buttons with per-button debounce and auto-repeat
module periph_input_decoder #(
    parameter int ADC_WIDTH = 12,
    parameter int NUM_CH = 5,
    parameter logic [NUM_CH-1:0] TERNARY_MASK = 5'b00111,
    parameter logic [ADC_WIDTH-1:0] HI_TH = 12'hCFF,
    parameter logic [ADC_WIDTH-1:0] MID_TH = 12'h5FF,
    parameter logic [ADC_WIDTH-1:0] BIN_TH = 12'h800,
    parameter int DEBOUNCE_SAMPLES = 4,
    parameter int REPEAT_DELAY = 20,
    parameter int REPEAT_PERIOD = 8
) (
    input logic clk,
    input logic reset,
    periph_input_decoder_if.slave dec_if
);
    localparam int NUM_BTN = 2 * NUM_CH;
    localparam int DW = $clog2(DEBOUNCE_SAMPLES + 1);
    localparam int REP_MAX = REPEAT_DELAY > REPEAT_PERIOD ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int RW = $clog2(REP_MAX + 1);
    localparam logic [DW-1:0] DB_LAST = DW'(DEBOUNCE_SAMPLES - 1);
    localparam logic [RW-1:0] REP_FIRST = RW'(REPEAT_DELAY - 1);
    localparam logic [RW-1:0] REP_NEXT = RW'(REPEAT_PERIOD - 1);
    localparam logic REP_EN = REPEAT_DELAY != 0;

    logic [NUM_BTN-1:0] cand, flip, held, hit;
    logic [NUM_BTN-1:0] level_q, level_d, press_q, press_d, rel_q, rel_d;
    logic [NUM_BTN-1:0] rpt_q, rpt_d, first_q, first_d;
    logic [DW-1:0] db_cnt_q [NUM_BTN];
    logic [DW-1:0] db_cnt_d [NUM_BTN];
    logic [RW-1:0] rep_cnt_q [NUM_BTN];
    logic [RW-1:0] rep_cnt_d [NUM_BTN];

    genvar c;
    for (c = 0; c < NUM_CH; c++) begin : g_ch
        logic [ADC_WIDTH-1:0] raw;
        assign raw = dec_if.ch_data[c*ADC_WIDTH +: ADC_WIDTH];
        assign cand[2*c] = TERNARY_MASK[c] ? raw > HI_TH : raw < BIN_TH;
        assign cand[2*c+1] = TERNARY_MASK[c] && raw > MID_TH && raw < HI_TH;
    end

    // A release in this cycle drops the button out of the held state, which also kills any due repeat
    always_comb begin
        flip = '0;
        held = '0;
        hit = '0;
        level_d = level_q;
        press_d = '0;
        rel_d = '0;
        rpt_d = '0;
        first_d = first_q;
        db_cnt_d = db_cnt_q;
        rep_cnt_d = rep_cnt_q;
        for (int b = 0; b < NUM_BTN; b++) begin
            flip[b] = dec_if.sample_valid && cand[b] != level_q[b] && db_cnt_q[b] == DB_LAST;
            level_d[b] = flip[b] ? cand[b] : level_q[b];
            press_d[b] = flip[b] && cand[b];
            rel_d[b] = flip[b] && !cand[b];
            db_cnt_d[b] = !dec_if.sample_valid ? db_cnt_q[b] :
                          (cand[b] == level_q[b] || flip[b]) ? '0 : db_cnt_q[b] + 1'b1;
            held[b] = level_q[b] && !rel_d[b];
            hit[b] = REP_EN && held[b] && rep_cnt_q[b] == (first_q[b] ? REP_NEXT : REP_FIRST);
            rpt_d[b] = hit[b];
            rep_cnt_d[b] = (!held[b] || hit[b]) ? '0 : rep_cnt_q[b] + 1'b1;
            first_d[b] = held[b] && (first_q[b] || hit[b]);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            level_q <= '0;
            press_q <= '0;
            rel_q <= '0;
            rpt_q <= '0;
            first_q <= '0;
            db_cnt_q <= '{default: '0};
            rep_cnt_q <= '{default: '0};
        end else begin
            level_q <= level_d;
            press_q <= press_d;
            rel_q <= rel_d;
            rpt_q <= rpt_d;
            first_q <= first_d;
            db_cnt_q <= db_cnt_d;
            rep_cnt_q <= rep_cnt_d;
        end
    end

    assign dec_if.btn_level = level_q;
    assign dec_if.btn_press = press_q;
    assign dec_if.btn_release = rel_q;
    assign dec_if.btn_repeat = rpt_q;
endmodule

// File: tb/tb_periph_input_decoder.sv
// tb_periph_input_decoder: directed scenarios plus random stimulus against a behavioural button model
module tb_periph_input_decoder;
    localparam int W = 12, NC = 5, NB = 2 * NC;
    localparam int DB = 4, RD = 20, RP = 8;
    localparam logic [NC-1:0] TM = 5'b00111;
    localparam logic [W*NC-1:0] NEUTRAL = {12'hFFF, 12'hFFF, 12'h000, 12'h000, 12'h000};

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    periph_input_decoder_if #(.ADC_WIDTH(W), .NUM_CH(NC)) dec_if ();

    periph_input_decoder #(
        .ADC_WIDTH(W), .NUM_CH(NC), .TERNARY_MASK(TM),
        .HI_TH(12'hCFF), .MID_TH(12'h5FF), .BIN_TH(12'h800),
        .DEBOUNCE_SAMPLES(DB), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)
    ) dut (
        .clk(clk),
        .reset(reset),
        .dec_if(dec_if)
    );

    logic [NB-1:0] m_lvl, m_prs, m_rel, m_rpt;
    int m_run [NB];
    int m_pt [NB];
    int cyc = 0;
    int tests = 0;
    int fails = 0;

    function automatic logic [NB-1:0] decode(input logic [W*NC-1:0] d);
        logic [NB-1:0] r = '0;
        logic [W-1:0] v;
        for (int i = 0; i < NC; i++) begin
            v = d[i*W +: W];
            if (TM[i]) begin
                r[2*i] = v > 12'hCFF;
                r[2*i+1] = v > 12'h5FF && v < 12'hCFF;
            end else begin
                r[2*i] = v < 12'h800;
            end
        end
        return r;
    endfunction

    function automatic logic [4*NB-1:0] dut_vec();
        return {dec_if.btn_level, dec_if.btn_press, dec_if.btn_release, dec_if.btn_repeat};
    endfunction

    function automatic logic [4*NB-1:0] ref_vec();
        return {m_lvl, m_prs, m_rel, m_rpt};
    endfunction

    // Drives one cycle, advances the model to the post-edge state, samples 1 time unit after the edge
    task automatic tick(input logic r, input logic sv, input logic [W*NC-1:0] d);
        logic [NB-1:0] cd;
        int dt;
        reset = r;
        dec_if.sample_valid = sv;
        dec_if.ch_data = d;
        cd = decode(d);
        cyc++;
        m_prs = '0;
        m_rel = '0;
        m_rpt = '0;
        if (r) begin
            m_lvl = '0;
            for (int b = 0; b < NB; b++) m_run[b] = 0;
        end else begin
            for (int b = 0; b < NB; b++) begin
                if (sv) begin
                    m_run[b] = (cd[b] == m_lvl[b]) ? 0 : m_run[b] + 1;
                    if (m_run[b] == DB) begin
                        m_lvl[b] = cd[b];
                        m_run[b] = 0;
                        m_prs[b] = cd[b];
                        m_rel[b] = !cd[b];
                        if (cd[b]) m_pt[b] = cyc;
                    end
                end
                dt = cyc - m_pt[b];
                m_rpt[b] = m_lvl[b] && RD > 0 && dt > 0 && (dt == RD || (dt > RD && (dt - RD) % RP == 0));
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 2; i++) tick(1'b1, 1'b0, NEUTRAL);
        if (dut_vec() !== '0) begin
            fails++;
            $display("FAIL reset_outputs: got %h want 0", dut_vec());
        end
        tests++;
        for (int i = 0; i < 3; i++) begin
            tick(1'b0, 1'b0, NEUTRAL);
            if (dut_vec() !== ref_vec()) begin
                fails++;
                $display("FAIL reset_idle cyc %0d: got %h want %h", cyc, dut_vec(), ref_vec());
            end
            tests++;
        end
    endtask

    task automatic test_band_decode();
        logic [W*NC-1:0] d = {12'h900, 12'h100, 12'hCFF, 12'h900, 12'hE00};
        for (int i = 0; i < 4; i++) begin
            tick(1'b0, 1'b1, d);
            if (dut_vec() !== ref_vec()) begin
                fails++;
                $display("FAIL band_model cyc %0d: got %h want %h", cyc, dut_vec(), ref_vec());
            end
            tests++;
        end
        if (dec_if.btn_level !== 10'b0001001001 || dec_if.btn_press !== 10'b0001001001) begin
            fails++;
            $display("FAIL band_press: level %b press %b want 0001001001", dec_if.btn_level, dec_if.btn_press);
        end
        tests++;
        tick(1'b0, 1'b0, d);
        if (dec_if.btn_press !== '0 || dec_if.btn_level !== 10'b0001001001) begin
            fails++;
            $display("FAIL band_pulse_width: level %b press %b", dec_if.btn_level, dec_if.btn_press);
        end
        tests++;
        for (int i = 0; i < 4; i++) tick(1'b0, 1'b1, NEUTRAL);
        if (dec_if.btn_level !== '0 || dec_if.btn_release !== 10'b0001001001) begin
            fails++;
            $display("FAIL band_release: level %b release %b want 0001001001", dec_if.btn_level, dec_if.btn_release);
        end
        tests++;
    endtask

    task automatic test_debounce_glitch();
        logic [W*NC-1:0] on = NEUTRAL | {{(W*NC-W){1'b0}}, 12'hE00};
        logic [W*NC-1:0] seq [7] = '{on, on, on, NEUTRAL, on, on, on};
        for (int i = 0; i < 7; i++) begin
            tick(1'b0, 1'b1, seq[i]);
            if (dec_if.btn_level[0] !== 1'b0 || dec_if.btn_press[0] !== 1'b0 || dut_vec() !== ref_vec()) begin
                fails++;
                $display("FAIL glitch_hold step %0d: got %h want %h", i, dut_vec(), ref_vec());
            end
            tests++;
        end
        tick(1'b0, 1'b1, on);
        if (dec_if.btn_level[0] !== 1'b1 || dec_if.btn_press[0] !== 1'b1) begin
            fails++;
            $display("FAIL glitch_press: level %b press %b want 1 1", dec_if.btn_level[0], dec_if.btn_press[0]);
        end
        tests++;
        tick(1'b0, 1'b0, on);
        if (dec_if.btn_press[0] !== 1'b0 || dec_if.btn_level[0] !== 1'b1) begin
            fails++;
            $display("FAIL glitch_pulse_width: level %b press %b want 1 0", dec_if.btn_level[0], dec_if.btn_press[0]);
        end
        tests++;
    endtask

    task automatic test_release();
        for (int i = 0; i < 4; i++) tick(1'b0, 1'b1, NEUTRAL);
        if (dec_if.btn_level[0] !== 1'b0 || dec_if.btn_release[0] !== 1'b1) begin
            fails++;
            $display("FAIL release_edge: level %b release %b want 0 1", dec_if.btn_level[0], dec_if.btn_release[0]);
        end
        tests++;
        for (int i = 0; i < 25; i++) begin
            tick(1'b0, 1'b0, NEUTRAL);
            if (dec_if.btn_release[0] !== 1'b0 || dec_if.btn_repeat[0] !== 1'b0 || dut_vec() !== ref_vec()) begin
                fails++;
                $display("FAIL release_quiet cyc %0d: got %h want %h", cyc, dut_vec(), ref_vec());
            end
            tests++;
        end
    endtask

    task automatic test_auto_repeat();
        logic [W*NC-1:0] d = {12'hFFF, 12'h100, 12'h000, 12'h000, 12'h000};
        int p = -1;
        logic exp;
        for (int i = 0; i < 10 && p < 0; i++) begin
            tick(1'b0, 1'b1, d);
            if (dec_if.btn_press[6] === 1'b1) p = cyc;
        end
        if (p < 0) begin
            fails++;
            $display("FAIL repeat_press_timeout: no press on btn 6 within 10 cycles");
        end
        tests++;
        for (int i = 0; i < 40; i++) begin
            tick(1'b0, 1'b1, d);
            exp = (cyc - p == 20) || (cyc - p == 28) || (cyc - p == 36);
            if (dec_if.btn_repeat[6] !== exp || dut_vec() !== ref_vec()) begin
                fails++;
                $display("FAIL repeat_schedule P+%0d: repeat %b want %b, got %h want %h", cyc - p, dec_if.btn_repeat[6], exp, dut_vec(), ref_vec());
            end
            tests++;
        end
        for (int i = 0; i < 6; i++) tick(1'b0, 1'b1, NEUTRAL);
        if (dut_vec() !== ref_vec() || dec_if.btn_level !== '0) begin
            fails++;
            $display("FAIL repeat_release: got %h want %h", dut_vec(), ref_vec());
        end
        tests++;
    endtask

    task automatic test_reset_mid();
        logic [W*NC-1:0] d = {12'hFFF, 12'h100, 12'h000, 12'h000, 12'h000};
        int p = -1;
        int n = 0;
        for (int i = 0; i < 10 && p < 0; i++) begin
            tick(1'b0, 1'b1, d);
            if (dec_if.btn_press[6] === 1'b1) p = cyc;
        end
        for (int i = 0; i < 10; i++) tick(1'b0, 1'b1, d);
        tick(1'b1, 1'b1, d);
        if (dut_vec() !== '0) begin
            fails++;
            $display("FAIL midreset_outputs: got %h want 0", dut_vec());
        end
        tests++;
        p = -1;
        for (int i = 0; i < 10 && p < 0; i++) begin
            tick(1'b0, 1'b1, d);
            n++;
            if (dec_if.btn_press[6] === 1'b1) p = cyc;
        end
        if (p < 0 || n != 4) begin
            fails++;
            $display("FAIL midreset_repress: press after %0d strobes want 4", n);
        end
        tests++;
        for (int i = 0; i < 25; i++) begin
            tick(1'b0, 1'b1, d);
            if (dec_if.btn_repeat[6] !== (cyc - p == 20) || dut_vec() !== ref_vec()) begin
                fails++;
                $display("FAIL midreset_repeat P+%0d: got %h want %h", cyc - p, dut_vec(), ref_vec());
            end
            tests++;
        end
        for (int i = 0; i < 6; i++) tick(1'b0, 1'b1, NEUTRAL);
    endtask

    task automatic test_sparse();
        logic [W*NC-1:0] d = {12'hFFF, 12'hFFF, 12'h000, 12'hE00, 12'h000};
        for (int s = 0; s < 4; s++) begin
            for (int j = 0; j < 5; j++) begin
                tick(1'b0, j == 0, d);
                if (dec_if.btn_level[2] !== (s == 3) || dut_vec() !== ref_vec()) begin
                    fails++;
                    $display("FAIL sparse strobe %0d gap %0d: level %b, got %h want %h", s, j, dec_if.btn_level[2], dut_vec(), ref_vec());
                end
                tests++;
            end
        end
        for (int i = 0; i < 6; i++) tick(1'b0, 1'b1, NEUTRAL);
    endtask

    task automatic test_random();
        logic [W*NC-1:0] d = NEUTRAL;
        logic [W-1:0] pool [8] = '{12'h000, 12'h5FF, 12'h600, 12'h7FF, 12'h800, 12'hCFF, 12'hD00, 12'hFFF};
        int ch;
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(0, 5) == 0) begin
                ch = $urandom_range(0, NC - 1);
                d[ch*W +: W] = ($urandom_range(0, 3) == 0) ? W'($urandom) : pool[$urandom_range(0, 7)];
            end
            tick($urandom_range(0, 299) == 0, $urandom_range(0, 3) != 0, d);
            if (dut_vec() !== ref_vec()) begin
                fails++;
                $display("FAIL random cyc %0d: got %h want %h", cyc, dut_vec(), ref_vec());
            end
            tests++;
        end
    endtask

    initial begin
        dec_if.sample_valid = 1'b0;
        dec_if.ch_data = NEUTRAL;
        m_lvl = '0;
        m_prs = '0;
        m_rel = '0;
        m_rpt = '0;
        for (int b = 0; b < NB; b++) begin
            m_run[b] = 0;
            m_pt[b] = 0;
        end
        test_reset();
        test_band_decode();
        test_debounce_glitch();
        test_release();
        test_auto_repeat();
        test_reset_mid();
        test_sparse();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
